// File: rtl/lcd_id_ctrl.sv
// Purpose: power-up sequencer that reads the 3 RGB LCD ID straps, debounces them and decodes panel geometry.
// Latency: cfg_valid rises SETTLE_CYC + (SAMPLE_NUM-1)*SAMPLE_GAP + 2 cycles after reset release on clean straps.
// Backpressure: none; rescan is a 1-cycle request honoured only once configuration is complete (DONE).
module lcd_id_ctrl #(
  parameter int SETTLE_CYC = 1000,
  parameter int SAMPLE_NUM = 4,
  parameter int SAMPLE_GAP = 50,
  parameter int MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rescan,
  input  logic [15:0] lcd_rgb_in,
  output logic        rgb_oe,
  output logic        cfg_valid,
  output logic        id_err,
  output logic [15:0] lcd_id,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic [1:0]  clk_sel
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
  localparam int SMP_W = $clog2(SAMPLE_NUM);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {S_SETTLE, S_SAMPLE, S_CHECK, S_FAIL, S_DONE} state_t;

  typedef struct packed {
    logic        ok;
    logic [15:0] id;
    logic [10:0] h;
    logic [10:0] v;
    logic [1:0]  cs;
  } dec_t;

  // Panel table; unsupported strap codes fall back to the 480x272 entry with ok cleared.
  function automatic dec_t decode(input logic [2:0] raw);
    case (raw)
      3'b000:  decode = '{1'b1, 16'h4342, 11'd480,  11'd272, 2'd0};
      3'b001:  decode = '{1'b1, 16'h7084, 11'd800,  11'd480, 2'd1};
      3'b010:  decode = '{1'b1, 16'h7016, 11'd1024, 11'd600, 2'd2};
      3'b100:  decode = '{1'b1, 16'h4384, 11'd800,  11'd480, 2'd1};
      3'b101:  decode = '{1'b1, 16'h1018, 11'd1280, 11'd800, 2'd3};
      default: decode = '{1'b0, 16'h4342, 11'd480,  11'd272, 2'd0};
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [SMP_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [RTY_W-1:0]   retry_cnt_q, retry_cnt_d;
  logic [2:0]         ref_id_q, ref_id_d;
  logic               mis_q, mis_d;
  logic               rgb_oe_q, rgb_oe_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic               id_err_q, id_err_d;
  logic [15:0]        lcd_id_q, lcd_id_d;
  logic [10:0]        h_disp_q, h_disp_d;
  logic [10:0]        v_disp_q, v_disp_d;
  logic [1:0]         clk_sel_q, clk_sel_d;

  logic [2:0] raw_id;
  dec_t       dec_ref;
  dec_t       dec_dflt;

  // Straps sit on the MSB of each colour channel: {B7,G7,R7}.
  assign raw_id   = {lcd_rgb_in[4], lcd_rgb_in[10], lcd_rgb_in[15]};
  assign dec_ref  = decode(ref_id_q);
  assign dec_dflt = decode(3'b000);

  // The remaining RGB pins carry pixel data and are of no interest here.
  logic unused_pins;
  assign unused_pins = ^{lcd_rgb_in[14:11], lcd_rgb_in[9:5], lcd_rgb_in[3:0]};

  // Next-state and output-load logic; counters default to clear so every state entry starts from zero.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = '0;
    gap_cnt_d    = '0;
    sample_cnt_d = '0;
    retry_cnt_d  = retry_cnt_q;
    ref_id_d     = ref_id_q;
    mis_d        = mis_q;
    id_err_d     = id_err_q;
    lcd_id_d     = lcd_id_q;
    h_disp_d     = h_disp_q;
    v_disp_d     = v_disp_q;
    clk_sel_d    = clk_sel_q;

    case (state_q)
      S_SETTLE: begin
        if (settle_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
          state_d = S_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end

      S_SAMPLE: begin
        if (sample_cnt_q == '0) begin
          // First cycle in SAMPLE: this reading becomes the reference.
          ref_id_d     = raw_id;
          sample_cnt_d = SMP_W'(1);
        end else if (gap_cnt_q == GAP_W'(SAMPLE_GAP - 1)) begin
          if (raw_id != ref_id_q) begin
            mis_d   = 1'b1;
            state_d = S_CHECK;
          end else if (sample_cnt_q == SMP_W'(SAMPLE_NUM - 1)) begin
            mis_d   = 1'b0;
            state_d = S_CHECK;
          end else begin
            sample_cnt_d = sample_cnt_q + SMP_W'(1);
          end
        end else begin
          sample_cnt_d = sample_cnt_q;
          gap_cnt_d    = gap_cnt_q + GAP_W'(1);
        end
      end

      S_CHECK: begin
        if (!mis_q) begin
          // Stable straps, but an unknown code is not worth retrying.
          if (dec_ref.ok) begin
            lcd_id_d  = dec_ref.id;
            h_disp_d  = dec_ref.h;
            v_disp_d  = dec_ref.v;
            clk_sel_d = dec_ref.cs;
            id_err_d  = 1'b0;
            state_d   = S_DONE;
          end else begin
            state_d = S_FAIL;
          end
        end else if (retry_cnt_q < RTY_W'(MAX_RETRY)) begin
          retry_cnt_d = retry_cnt_q + RTY_W'(1);
          state_d     = S_SETTLE;
        end else begin
          state_d = S_FAIL;
        end
      end

      S_FAIL: begin
        lcd_id_d  = dec_dflt.id;
        h_disp_d  = dec_dflt.h;
        v_disp_d  = dec_dflt.v;
        clk_sel_d = dec_dflt.cs;
        id_err_d  = 1'b1;
        state_d   = S_DONE;
      end

      S_DONE: begin
        // Geometry is kept across a rescan so the driver sees the last good values until reload.
        if (rescan) begin
          id_err_d    = 1'b0;
          retry_cnt_d = '0;
          state_d     = S_SETTLE;
        end
      end

      default: state_d = S_SETTLE;
    endcase

    // Pin ownership and valid flip together on entry to / exit from DONE.
    cfg_valid_d = (state_d == S_DONE);
    rgb_oe_d    = (state_d == S_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_SETTLE;
      settle_cnt_q <= '0;
      gap_cnt_q    <= '0;
      sample_cnt_q <= '0;
      retry_cnt_q  <= '0;
      ref_id_q     <= '0;
      mis_q        <= 1'b0;
      rgb_oe_q     <= 1'b0;
      cfg_valid_q  <= 1'b0;
      id_err_q     <= 1'b0;
      lcd_id_q     <= '0;
      h_disp_q     <= '0;
      v_disp_q     <= '0;
      clk_sel_q    <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      ref_id_q     <= ref_id_d;
      mis_q        <= mis_d;
      rgb_oe_q     <= rgb_oe_d;
      cfg_valid_q  <= cfg_valid_d;
      id_err_q     <= id_err_d;
      lcd_id_q     <= lcd_id_d;
      h_disp_q     <= h_disp_d;
      v_disp_q     <= v_disp_d;
      clk_sel_q    <= clk_sel_d;
    end
  end

  assign rgb_oe    = rgb_oe_q;
  assign cfg_valid = cfg_valid_q;
  assign id_err    = id_err_q;
  assign lcd_id    = lcd_id_q;
  assign h_disp    = h_disp_q;
  assign v_disp    = v_disp_q;
  assign clk_sel   = clk_sel_q;

endmodule

// File: tb/tb_lcd_id_ctrl.sv
// Purpose: self-checking bench for lcd_id_ctrl against a timeline model of the strap sampling rules.
// Latency: model predicts the exact cycle cfg_valid rises, relative to reset release or rescan.
// Backpressure: none; rescan is pulsed in and out of DONE to check it is honoured only there.
module tb_lcd_id_ctrl;

  localparam int SC   = 1000;
  localparam int SN   = 4;
  localparam int SG   = 50;
  localparam int MR   = 3;
  localparam int NMAX = 5000;

  typedef struct packed {
    logic        rgb_oe;
    logic        cfg_valid;
    logic        id_err;
    logic [15:0] id;
    logic [10:0] h;
    logic [10:0] v;
    logic [1:0]  cs;
  } out_t;

  logic        clk;
  logic        rst_n;
  logic        rescan;
  logic [15:0] lcd_rgb_in;
  logic        rgb_oe;
  logic        cfg_valid;
  logic        id_err;
  logic [15:0] lcd_id;
  logic [10:0] h_disp;
  logic [10:0] v_disp;
  logic [1:0]  clk_sel;

  lcd_id_ctrl #(
    .SETTLE_CYC (SC),
    .SAMPLE_NUM (SN),
    .SAMPLE_GAP (SG),
    .MAX_RETRY  (MR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rescan     (rescan),
    .lcd_rgb_in (lcd_rgb_in),
    .rgb_oe     (rgb_oe),
    .cfg_valid  (cfg_valid),
    .id_err     (id_err),
    .lcd_id     (lcd_id),
    .h_disp     (h_disp),
    .v_disp     (v_disp),
    .clk_sel    (clk_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strap value per cycle of the current run, cycle 0 = first SETTLE cycle.
  logic [2:0] pins [NMAX];
  int   exp_done;
  out_t exp_cfg;
  out_t prev_cfg;
  int   checks;
  int   errors;

  function automatic out_t panel(input logic [2:0] raw, input logic err);
    out_t o;
    case (raw)
      3'd1:    o = '{1'b1, 1'b1, err, 16'h7084, 11'd800,  11'd480, 2'd1};
      3'd2:    o = '{1'b1, 1'b1, err, 16'h7016, 11'd1024, 11'd600, 2'd2};
      3'd4:    o = '{1'b1, 1'b1, err, 16'h4384, 11'd800,  11'd480, 2'd1};
      3'd5:    o = '{1'b1, 1'b1, err, 16'h1018, 11'd1280, 11'd800, 2'd3};
      default: o = '{1'b1, 1'b1, err, 16'h4342, 11'd480,  11'd272, 2'd0};
    endcase
    return o;
  endfunction

  function automatic bit supported(input logic [2:0] raw);
    return (raw == 3'd0) || (raw == 3'd1) || (raw == 3'd2) || (raw == 3'd4) || (raw == 3'd5);
  endfunction

  // Walk the sampling passes on the strap timeline and find when and what the DUT must report.
  task automatic build_model();
    int s0, bad, chk;
    logic [2:0] r0;
    for (int pass = 0; pass <= MR; pass++) begin
      s0  = (pass == 0) ? SC : exp_done + SC;
      r0  = pins[s0];
      bad = -1;
      for (int k = 1; k < SN; k++) begin
        if (bad < 0 && pins[s0 + k*SG] != r0) bad = s0 + k*SG;
      end
      if (bad >= 0) begin
        chk = bad + 1;
        if (pass < MR) begin
          exp_done = chk + 1;        // start of the next pass, reused as pass origin
          continue;
        end
        exp_done = chk + 2;
        exp_cfg  = panel(3'd0, 1'b1);
        return;
      end
      chk = s0 + (SN-1)*SG + 1;
      if (supported(r0)) begin
        exp_done = chk + 1;
        exp_cfg  = panel(r0, 1'b0);
      end else begin
        exp_done = chk + 2;
        exp_cfg  = panel(3'd0, 1'b1);
      end
      return;
    end
  endtask

  task automatic pin_model(input string tag, input int want_done, input out_t want);
    checks++;
    if (exp_done != want_done || exp_cfg != want) begin
      errors++;
      $display("FAIL model_%s done=%0d cfg=%h required done=%0d cfg=%h", tag, exp_done, exp_cfg, want_done, want);
    end
  endtask

  task automatic drive_pins(input int r);
    logic [15:0] v;
    v      = 16'($urandom);
    v[15]  = pins[r][0];
    v[10]  = pins[r][1];
    v[4]   = pins[r][2];
    lcd_rgb_in = v;
  endtask

  task automatic check_out(input string tag, input int r);
    out_t act, expv;
    act = {rgb_oe, cfg_valid, id_err, lcd_id, h_disp, v_disp, clk_sel};
    if (r >= exp_done) expv = exp_cfg;
    else expv = {1'b0, 1'b0, 1'b0, prev_cfg.id, prev_cfg.h, prev_cfg.v, prev_cfg.cs};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, r, act, expv);
    end
  endtask

  task automatic do_reset(input string tag);
    rescan = 1'b0;
    rst_n  = 1'b0;
    #1;
    checks++;
    if ({rgb_oe, cfg_valid, id_err, lcd_id, h_disp, v_disp, clk_sel} !== '0) begin
      errors++;
      $display("FAIL reset_%s got=%h expected=0", tag, {rgb_oe, cfg_valid, id_err, lcd_id, h_disp, v_disp, clk_sel});
    end
    prev_cfg = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Caller is at #1 after a DUT edge in DONE; the pulse turns the next cycle into run cycle 0.
  task automatic do_rescan();
    rescan = 1'b1;
    @(posedge clk);
    #1;
    rescan = 1'b0;
  endtask

  task automatic run_seq(input string tag, input int stop_r, input bit noise);
    int last;
    last = (stop_r >= 0) ? stop_r : exp_done + 4;
    drive_pins(0);
    check_out(tag, 0);
    for (int r = 1; r <= last; r++) begin
      @(posedge clk);
      #1;
      rescan = 1'b0;
      drive_pins(r);
      check_out(tag, r);
      if (noise && r < exp_done - 1 && (r == 500 || $urandom_range(0, 299) == 0)) rescan = 1'b1;
    end
    rescan = 1'b0;
  endtask

  task automatic fill_static(input logic [2:0] v);
    for (int i = 0; i < NMAX; i++) pins[i] = v;
  endtask

  task automatic fill_random();
    int r, len;
    logic [2:0] v;
    r = 0;
    while (r < NMAX) begin
      len = $urandom_range(30, 1400);
      case ($urandom_range(0, 6))
        0: v = 3'd0;
        1: v = 3'd1;
        2: v = 3'd2;
        3: v = 3'd4;
        4: v = 3'd5;
        default: v = 3'($urandom_range(0, 7));
      endcase
      for (int i = 0; i < len; i++) begin
        if (r < NMAX) pins[r] = v;
        r++;
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b1;
    rescan     = 1'b0;
    lcd_rgb_in = '0;
    prev_cfg   = '0;
    #3;

    // Clean straps 001 from reset.
    fill_static(3'b001);
    build_model();
    pin_model("static001", 1152, '{1'b1, 1'b1, 1'b0, 16'h7084, 11'd800, 11'd480, 2'd1});
    do_reset("initial");
    run_seq("static001", -1, 1'b0);

    // 010 then 000 on the first two samples, then stable 101: one retry.
    prev_cfg = exp_cfg;
    for (int i = 0; i < NMAX; i++) pins[i] = (i <= 1025) ? 3'b010 : (i <= 1075) ? 3'b000 : 3'b101;
    build_model();
    pin_model("retry101", 2204, '{1'b1, 1'b1, 1'b0, 16'h1018, 11'd1280, 11'd800, 2'd3});
    do_rescan();
    run_seq("retry101", -1, 1'b0);

    // Straps toggling 000/001 every 50 cycles: all retries burn, default panel.
    prev_cfg = exp_cfg;
    for (int i = 0; i < NMAX; i++) pins[i] = ((i / 50) % 2 == 1) ? 3'b001 : 3'b000;
    build_model();
    pin_model("toggle", 4209, '{1'b1, 1'b1, 1'b1, 16'h4342, 11'd480, 11'd272, 2'd0});
    do_rescan();
    run_seq("toggle", -1, 1'b0);

    // Unsupported 111: no retry, default panel via the one-cycle fail step.
    prev_cfg = exp_cfg;
    fill_static(3'b111);
    build_model();
    pin_model("static111", 1153, '{1'b1, 1'b1, 1'b1, 16'h4342, 11'd480, 11'd272, 2'd0});
    do_rescan();
    run_seq("static111", -1, 1'b0);

    // Rescan with 100: old geometry holds while cfg_valid is low, then reloads.
    prev_cfg = exp_cfg;
    fill_static(3'b100);
    build_model();
    pin_model("rescan100", 1152, '{1'b1, 1'b1, 1'b0, 16'h4384, 11'd800, 11'd480, 2'd1});
    do_rescan();
    run_seq("rescan100", -1, 1'b0);

    // Reset in the middle of sampling, then a full sequence with stray rescans before DONE.
    prev_cfg = exp_cfg;
    fill_static(3'b010);
    build_model();
    do_rescan();
    run_seq("pre_reset", 1075, 1'b0);
    #2;
    do_reset("mid_sample");
    run_seq("post_reset", -1, 1'b1);

    // Randomised strap timelines.
    for (int n = 0; n < 4; n++) begin
      prev_cfg = exp_cfg;
      fill_random();
      build_model();
      do_rescan();
      run_seq($sformatf("random%0d", n), -1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_id_ctrl.md
Name: lcd_id_ctrl

Overview:
Power-up sequencer for RGB LCD panel identification. After reset it holds the LCD RGB pins as inputs and waits for the panel strap levels to settle. It then samples the 3 ID strap bits several times and requires every sample to agree. It decodes the result into a panel ID code and display geometry, then releases the pins to the timing/pixel driver by asserting cfg_valid.

Parameters:
SETTLE_CYC, 1000, clk cycles to wait with pins as inputs before the first sample (min 1)
SAMPLE_NUM, 4, consecutive samples that must agree (2..16)
SAMPLE_GAP, 50, clk cycles between samples (min 1)
MAX_RETRY, 3, mismatch restarts allowed before falling back to the default panel (0..7)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rescan  in  1  1-cycle pulse; restarts identification (honoured only in DONE)
lcd_rgb_in  in  16  RGB565 pin inputs; ID straps are R7=bit15, G7=bit10, B7=bit4
rgb_oe  out  1  1 = pixel driver owns pins; 0 = pins tri-stated for ID read
cfg_valid  out  1  ID and geometry outputs valid
id_err  out  1  retries exhausted; default panel reported
lcd_id  out  16  panel ID code
h_disp  out  11  active pixels per line
v_disp  out  11  active lines per frame
clk_sel  out  2  pixel clock select: 0=9MHz, 1=33MHz, 2=50MHz, 3=70MHz

Behaviour:
- Reset values (async): state=SETTLE, rgb_oe=0, cfg_valid=0, id_err=0, lcd_id=0, h_disp=0, v_disp=0, clk_sel=0. All counters are 0.
- Raw 3-bit ID = {B7,G7,R7} = {lcd_rgb_in[4], lcd_rgb_in[10], lcd_rgb_in[15]}.
- States: SETTLE -> SAMPLE -> CHECK -> DONE. FAIL is a one-cycle state leading to DONE.
- SETTLE: rgb_oe=0, cfg_valid=0. Count SETTLE_CYC cycles, then enter SAMPLE with sample_cnt=0.
- SAMPLE:
  - On entry cycle, capture the first sample as ref_id.
  - Each further sample is taken SAMPLE_GAP cycles after the previous one and compared to ref_id.
  - Any mismatch -> CHECK with mismatch flag set.
  - After SAMPLE_NUM total samples with no mismatch -> CHECK with flag clear.
- CHECK (1 cycle):
  - Flag clear -> load decoded outputs, enter DONE.
  - Flag set and retry_cnt < MAX_RETRY -> retry_cnt++, back to SETTLE (full settle wait).
  - Flag set and retry_cnt = MAX_RETRY -> FAIL.
- FAIL: load the default decode (raw 000 entry), set id_err=1, enter DONE.
- DONE: cfg_valid=1 and rgb_oe=1, both registered and asserted in the same cycle. All outputs hold.
- Decode table (raw -> lcd_id, h_disp, v_disp, clk_sel):
  - 000 -> 0x4342, 480, 272, 0
  - 001 -> 0x7084, 800, 480, 1
  - 010 -> 0x7016, 1024, 600, 2
  - 100 -> 0x4384, 800, 480, 1
  - 101 -> 0x1018, 1280, 800, 3
  - 011/110/111 are unsupported: treat as a failed identification, go to FAIL immediately from CHECK with no retry.
- Latency, clean pins: cfg_valid rises SETTLE_CYC + (SAMPLE_NUM-1)*SAMPLE_GAP + 2 cycles after reset release (±1 for the registered output; the bench checks the exact value once implemented and pins it in the regression).
- rescan in DONE:
  - Next cycle: cfg_valid=0, rgb_oe=0, id_err=0, retry_cnt=0, state=SETTLE.
  - lcd_id, h_disp, v_disp and clk_sel keep their old values until the next load.
- rescan outside DONE is ignored.
- Reset asserted mid-operation returns all outputs to reset values immediately. The sequence restarts from SETTLE on release.
- Counters are sized by $clog2 of their maximum. No counter wraps; each clears on every state entry.

Test Plan:
- Pins static raw=001, SETTLE_CYC=1000, SAMPLE_NUM=4, SAMPLE_GAP=50 -> cfg_valid and rgb_oe rise together at the computed latency; lcd_id=0x7084, h_disp=800, v_disp=480, clk_sel=1, id_err=0.
- Raw=010 for the 1st sample, 000 for the 2nd, then stable 101 -> one retry, full settle repeated; final lcd_id=0x1018, h_disp=1280, v_disp=800, clk_sel=3, id_err=0.
- Pins toggling 000/001 every 50 cycles for the whole run, MAX_RETRY=3 -> 4 sampling passes, then id_err=1, lcd_id=0x4342, 480x272, cfg_valid=1.
- Static raw=111 -> no retry; id_err=1, default 0x4342 at the first-pass latency.
- In DONE with raw=100, pulse rescan -> next cycle cfg_valid=0, rgb_oe=0, lcd_id still holds the old value; later lcd_id=0x4384, 800x480, clk_sel=1.
- Assert rst_n low during SAMPLE -> all outputs reset asynchronously; after release a full sequence completes normally. Also pulse rescan during SETTLE -> no effect on timing.
